// File: rtl/accum_sequencer.sv
// Control stage for the 16-bit accumulator datapath.
// It sequences CLEAR and then terms 1..n so the datapath sum becomes n(n+1)/2.
//
// Ports:
//   clk        rising-edge clock, shared with the datapath
//   rst        synchronous, active-high reset
//   start      request a new run; only sampled in IDLE and HOLD
//   n_in       operand n, latched when start is accepted
//   n_out      term driven to the datapath N input
//   select     datapath mux select (0 = constant 0, 1 = n_out)
//   alu_opcode datapath ALU opcode
//   eo         datapath triangle_control enable
//   busy       high in CLEAR and ACCUM
//   done       high in HOLD, when the result is valid
//   ovf        latched when n exceeds the largest n whose sum fits in WIDTH bits
module accum_sequencer #(
  parameter int          WIDTH      = 16,
  parameter logic [2:0]  OP_ADD     = 3'b000,
  parameter logic [2:0]  OP_PASS_A  = 3'b111,
  parameter int          MAX_SAFE_N = 361
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic [WIDTH-1:0] n_out,
  output logic             select,
  output logic [2:0]       alu_opcode,
  output logic             eo,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] ACCUM = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [WIDTH-1:0] SAFE_N = WIDTH'(MAX_SAFE_N);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] k_nxt;
  logic [WIDTH-1:0] n_lat;
  logic [WIDTH-1:0] n_lat_nxt;
  logic             ovf_nxt;

  logic [WIDTH-1:0] n_out_nxt;
  logic             select_nxt;
  logic [2:0]       opcode_nxt;
  logic             eo_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Next-state and run bookkeeping.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    n_lat_nxt = n_lat;
    ovf_nxt   = ovf;
    case (state)
      IDLE, HOLD: begin
        if (start) begin
          state_nxt = CLEAR;
          n_lat_nxt = n_in;
          ovf_nxt   = (n_in > SAFE_N);
          k_nxt     = '0;
        end
      end
      CLEAR: begin
        if (n_lat != '0) begin
          state_nxt = ACCUM;
          k_nxt     = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          state_nxt = HOLD;
        end
      end
      ACCUM: begin
        // k stops at n_lat, so it never wraps even for n_lat = 2^WIDTH-1.
        if (k == n_lat) begin
          state_nxt = HOLD;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they move with the state.
  always_comb begin
    n_out_nxt  = '0;
    select_nxt = 1'b0;
    opcode_nxt = OP_ADD;
    eo_nxt     = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    unique case (1'b1)
      (state_nxt == CLEAR): begin
        // Pass constant 0 through the ALU to wipe the unreset sum.
        opcode_nxt = OP_PASS_A;
        busy_nxt   = 1'b1;
      end
      (state_nxt == ACCUM): begin
        select_nxt = 1'b1;
        n_out_nxt  = k_nxt;
        busy_nxt   = 1'b1;
      end
      (state_nxt == HOLD): begin
        eo_nxt   = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      n_lat      <= '0;
      ovf        <= 1'b0;
      n_out      <= '0;
      select     <= 1'b0;
      alu_opcode <= OP_ADD;
      eo         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      n_lat      <= n_lat_nxt;
      ovf        <= ovf_nxt;
      n_out      <= n_out_nxt;
      select     <= select_nxt;
      alu_opcode <= opcode_nxt;
      eo         <= eo_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// Randomized bench for accum_sequencer.
// A timeline model plus a small datapath model derive every expected value.
module tb_accum_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] n_in;
  logic [15:0] n_out;
  logic        select;
  logic [2:0]  alu_opcode;
  logic        eo;
  logic        busy;
  logic        done;
  logic        ovf;

  always #5 clk = ~clk;

  accum_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .n_in(n_in),
    .n_out(n_out),
    .select(select),
    .alu_opcode(alu_opcode),
    .eo(eo),
    .busy(busy),
    .done(done),
    .ovf(ovf)
  );

  // Datapath: unreset sum register followed by one shift_register stage.
  logic [15:0] dp_sum = 16'hbeef;
  logic [15:0] dp_res = 16'h1234;

  always @(posedge clk) begin
    if (alu_opcode == 3'b111)
      dp_sum <= select ? n_out : 16'd0;
    else
      dp_sum <= (select ? n_out : 16'd0) + dp_sum;
    dp_res <= dp_sum;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model: edges since the accepted start, and the latched n.
  bit m_act = 0;
  int m_n   = 0;
  int m_cyc = 0;
  bit m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic r, input logic st, input logic [15:0] nin);
    logic        e_sel;
    logic [2:0]  e_op;
    logic [15:0] e_nout;
    logic        e_busy;
    logic        e_done;
    logic [15:0] tri_v;
    bit          hold;
    rst   = r;
    start = st;
    n_in  = nin;
    @(posedge clk);
    if (r) begin
      m_act = 0;
      m_ovf = 0;
    end else if (st && (!m_act || m_cyc >= m_n + 2)) begin
      m_act = 1;
      m_n   = int'(nin);
      m_ovf = (int'(nin) > 361);
      m_cyc = 1;
    end else if (m_act && m_cyc < m_n + 4) begin
      m_cyc++;
    end
    #1;
    e_sel  = 0;
    e_op   = 3'b000;
    e_nout = 0;
    e_busy = 0;
    e_done = 0;
    hold   = 0;
    if (m_act) begin
      if (m_cyc == 1) begin
        e_op   = 3'b111;
        e_busy = 1;
      end else if (m_cyc <= m_n + 1) begin
        e_sel  = 1;
        e_nout = 16'(m_cyc - 1);
        e_busy = 1;
      end else begin
        e_done = 1;
        hold   = 1;
      end
    end
    chk("select", 32'(select), 32'(e_sel));
    chk("opcode", 32'(alu_opcode), 32'(e_op));
    chk("n_out", 32'(n_out), 32'(e_nout));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("eo", 32'(eo), 32'(e_done));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    tri_v = 16'((longint'(m_n) * longint'(m_n + 1) / 2) % 65536);
    if (hold) chk("sum", 32'(dp_sum), 32'(tri_v));
    if (hold && m_cyc >= m_n + 3) chk("result", 32'(dp_res), 32'(tri_v));
  endtask

  // Full run: accept n, random ignored starts while busy, then hold.
  task automatic go(input logic [15:0] n, input int hold_cyc);
    tick(0, 1, n);
    repeat (int'(n) + 1) tick(0, 1'($urandom_range(0, 1)), 16'($urandom));
    repeat (hold_cyc) tick(0, 0, 16'($urandom));
  endtask

  initial begin
    rst   = 1;
    start = 1;
    n_in  = 7;
    tick(1, 1, 7);
    tick(1, 1, 7);
    tick(0, 0, 7);
    go(5, 3);
    go(0, 2);
    go(361, 2);
    go(362, 2);
    go(1, 2);
    // start held high across a run, n_in changed mid-run
    tick(0, 1, 3);
    for (int i = 0; i < 4; i++) tick(0, 1, (i < 2) ? 16'd3 : 16'd9);
    tick(0, 1, 9);
    repeat (10) tick(0, 1, 9);
    repeat (2) tick(0, 0, 9);
    // reset during the third ACCUM cycle of n=10
    tick(0, 1, 10);
    repeat (3) tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    go(4, 3);
    for (int r = 0; r < 30; r++) begin
      go(16'($urandom_range(0, 60)), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) tick(1, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) == 0) tick(0, 0, 16'($urandom));
    end
    go(16'($urandom_range(300, 420)), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Control stage directly upstream of the 16-bit accumulator datapath (mux16b -> alu_16bit -> shift_register -> triangle_control).
- Drives the datapath's N, select, alu_opcode and EO inputs so that it computes the triangular sum 1+2+...+n for an operand loaded on start.
- Enables the tri-state output once the sum is valid.
- Provides a busy/done handshake and an overflow flag.

Parameters:
- WIDTH, 16: datapath and operand width.
- OP_ADD, 3'b000: alu_opcode value for in_a + in_b.
- OP_PASS_A, 3'b111: alu_opcode value for result = in_a.
- MAX_SAFE_N, 361: largest n whose triangular sum fits in WIDTH bits (361*362/2 = 65341).

Ports:
- clk  in  1  rising-edge clock, shared with the datapath.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new computation; sampled only in IDLE and HOLD.
- n_in  in  WIDTH  operand n, latched on an accepted start.
- n_out  out  WIDTH  term fed to the datapath N input.
- select  out  1  datapath mux select (0 = constant 0, 1 = n_out).
- alu_opcode  out  3  datapath ALU opcode.
- eo  out  1  datapath triangle_control enable.
- busy  out  1  high in CLEAR and ACCUM.
- done  out  1  high while in HOLD (result valid on the datapath result).
- ovf  out  1  latched: n_lat > MAX_SAFE_N for the current run.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, n_out=0, select=0, alu_opcode=OP_ADD, eo=0, busy=0, done=0, ovf=0, k=0, n_lat=0.
- rst is asserted mid-run: the run aborts at the next edge, and all outputs take their reset values.
- The datapath sum register has no reset. Every run therefore starts with CLEAR; the sequencer never relies on the prior sum.
- Outputs are registered, decoded from the next state, so they change on the same edge as the state.
- Datapath recurrence every edge: sum <= op(mux_out, sum). select=0 with OP_ADD holds sum. select=0 with OP_PASS_A zeroes sum.
- States:
  - IDLE:
    - Outputs: select=0, OP_ADD, eo=0, busy=0, done=0.
    - start=1: latch n_lat=n_in, set ovf=(n_in > MAX_SAFE_N), go to CLEAR.
  - CLEAR (1 cycle):
    - Outputs: select=0, OP_PASS_A, n_out=0, busy=1.
    - Next: ACCUM with k=1 if n_lat != 0; HOLD if n_lat == 0.
  - ACCUM:
    - Outputs: select=1, n_out=k, OP_ADD, busy=1.
    - On each edge: if k == n_lat, go to HOLD; otherwise k <= k+1.
    - Lasts exactly n_lat cycles.
  - HOLD:
    - Outputs: select=0, OP_ADD (sum held), eo=1, done=1, busy=0.
    - start=1 relatches n_in, updates ovf and goes to CLEAR (eo and done drop on that edge).
    - Otherwise stays in HOLD.
- start in CLEAR or ACCUM is ignored. n_in changes after acceptance have no effect.
- Latency: done rises n_lat+2 edges after the edge that accepted start (the n_lat=0 case gives 2).
- Datapath result equals the sum one cycle after done rises, through the shift_register stage.
- Arithmetic wraps modulo 2^WIDTH in the datapath. ovf is advisory only; the sequence still runs all n_lat terms.
- k is WIDTH bits wide. With n_lat=65535, k reaches 65535 without wrapping before the k == n_lat compare.

Test Plan:
1. rst high for 2 cycles with start=1 -> busy=0, done=0, eo=0, select=0, alu_opcode=OP_ADD throughout.
2. n_in=5, start pulse from IDLE -> one CLEAR cycle; ACCUM drives n_out 1,2,3,4,5; done at edge 7; datapath result=15 with eo=1.
3. n_in=0, start -> CLEAR then HOLD; done after 2 edges; result=0; ovf=0.
4. n_in=361 -> result=65341, ovf=0. n_in=362 -> ovf=1, result=65703 mod 65536=167.
5. start held high through a run with n_in=3, n_in changed to 9 mid-run -> first result=6. The held start restarts from HOLD with n=9 -> result=45.
6. rst asserted at the 3rd ACCUM cycle of n=10 -> IDLE next edge, outputs at reset values. A new start with n=4 -> result=10 (CLEAR removes the stale sum).
